// File: rtl/serv_exec_sequencer.sv
// rtl/serv_exec_sequencer.sv - fetch / init / mem-or-shift / run sequencer for the bit-serial core
// Optional dbus wait timeout: define SERV_SEQ_DBUS_TIMEOUT_EN.
module serv_exec_sequencer #(
  parameter int W            = 1,
  parameter int DBUS_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       i_rst,
  output logic       o_ibus_cyc,
  input  logic       i_ibus_ack,
  output logic       o_wb_en,
  input  logic       i_two_stage_op,
  input  logic       i_dbus_en,
  input  logic       i_shift_op,
  input  logic       i_sh_done,
  output logic       o_rf_rreq,
  input  logic       i_rf_ready,
  output logic       o_cnt_en,
  output logic [4:0] o_cnt,
  output logic       o_cnt_done,
  output logic       o_init,
  output logic       o_ctrl_pc_en,
  output logic       o_dbus_cyc,
  input  logic       i_dbus_ack,
  output logic       o_dbus_err
);

  localparam logic [4:0] CNT_STEP = 5'(W);
  localparam logic [4:0] CNT_LAST = 5'(32 - W);

  typedef enum logic [2:0] {FETCH, RF_REQ, INIT, MEM, SHIFT, RUN} state_t;

  state_t     state, state_next;
  logic       stage2, stage2_next;
  logic [4:0] cnt_next;
  logic       timeout;

  assign o_wb_en    = o_ibus_cyc & i_ibus_ack;
  assign o_cnt_done = o_cnt_en & (o_cnt == CNT_LAST);

`ifdef SERV_SEQ_DBUS_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(DBUS_TIMEOUT - 1);

  logic [7:0] wait_cnt;
  logic       dbus_err_q;

  // An ack in the final wait cycle suppresses the timeout.
  assign timeout    = (state == MEM) & ~i_dbus_ack & (wait_cnt == WAIT_LAST);
  assign o_dbus_err = dbus_err_q;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt   <= '0;
      dbus_err_q <= 1'b0;
    end else begin
      dbus_err_q <= timeout;
      if (state != MEM)
        wait_cnt <= '0;
      else if (!i_dbus_ack)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout    = 1'b0;
  assign o_dbus_err = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    stage2_next = stage2;
    cnt_next    = '0;
    case (state)
      FETCH: begin
        if (o_wb_en) begin
          state_next  = RF_REQ;
          stage2_next = 1'b0;
        end
      end
      RF_REQ: begin
        if (i_rf_ready)
          state_next = (i_two_stage_op && !stage2) ? INIT : RUN;
      end
      INIT: begin
        if (o_cnt_done) begin
          stage2_next = 1'b1;
          if (i_dbus_en)       state_next = MEM;
          else if (i_shift_op) state_next = SHIFT;
          else                 state_next = RF_REQ;
        end else begin
          cnt_next = o_cnt + CNT_STEP;
        end
      end
      MEM: begin
        if (i_dbus_ack)   state_next = RF_REQ;
        else if (timeout) state_next = FETCH;
      end
      SHIFT: begin
        if (i_sh_done) state_next = RF_REQ;
      end
      RUN: begin
        if (o_cnt_done) state_next = FETCH;
        else            cnt_next = o_cnt + CNT_STEP;
      end
      default: state_next = FETCH;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= FETCH;
      stage2       <= 1'b0;
      o_cnt        <= '0;
      o_ibus_cyc   <= 1'b0;
      o_rf_rreq    <= 1'b0;
      o_cnt_en     <= 1'b0;
      o_init       <= 1'b0;
      o_ctrl_pc_en <= 1'b0;
      o_dbus_cyc   <= 1'b0;
    end else begin
      state        <= state_next;
      stage2       <= stage2_next;
      o_cnt        <= cnt_next;
      o_ibus_cyc   <= (state_next == FETCH);
      o_rf_rreq    <= (state_next == RF_REQ);
      o_cnt_en     <= (state_next == INIT) || (state_next == RUN);
      o_init       <= (state_next == INIT);
      o_ctrl_pc_en <= (state_next == RUN);
      o_dbus_cyc   <= (state_next == MEM);
    end
  end

endmodule

// File: tb/tb_serv_exec_sequencer.sv
// tb/tb_serv_exec_sequencer.sv - randomized trace-model bench for serv_exec_sequencer (W=1 and W=4 instances)
module tb_serv_exec_sequencer;

  localparam int TO = 4;
`ifdef SERV_SEQ_DBUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ibus_ack, two_stage_op, dbus_en, shift_op, sh_done, rf_ready, dbus_ack;

  logic       ibus_cyc_a, wb_en_a, rf_rreq_a, cnt_en_a, cnt_done_a, init_a, pc_en_a, dbus_cyc_a, dbus_err_a;
  logic [4:0] cnt_a;
  logic       ibus_cyc_b, wb_en_b, rf_rreq_b, cnt_en_b, cnt_done_b, init_b, pc_en_b, dbus_cyc_b, dbus_err_b;
  logic [4:0] cnt_b;

  serv_exec_sequencer #(.W(1), .DBUS_TIMEOUT(TO)) dut_a (
    .clk(clk), .i_rst(rst), .o_ibus_cyc(ibus_cyc_a), .i_ibus_ack(ibus_ack), .o_wb_en(wb_en_a),
    .i_two_stage_op(two_stage_op), .i_dbus_en(dbus_en), .i_shift_op(shift_op), .i_sh_done(sh_done),
    .o_rf_rreq(rf_rreq_a), .i_rf_ready(rf_ready), .o_cnt_en(cnt_en_a), .o_cnt(cnt_a),
    .o_cnt_done(cnt_done_a), .o_init(init_a), .o_ctrl_pc_en(pc_en_a), .o_dbus_cyc(dbus_cyc_a),
    .i_dbus_ack(dbus_ack), .o_dbus_err(dbus_err_a));

  serv_exec_sequencer #(.W(4), .DBUS_TIMEOUT(TO)) dut_b (
    .clk(clk), .i_rst(rst), .o_ibus_cyc(ibus_cyc_b), .i_ibus_ack(ibus_ack), .o_wb_en(wb_en_b),
    .i_two_stage_op(two_stage_op), .i_dbus_en(dbus_en), .i_shift_op(shift_op), .i_sh_done(sh_done),
    .o_rf_rreq(rf_rreq_b), .i_rf_ready(rf_ready), .o_cnt_en(cnt_en_b), .o_cnt(cnt_b),
    .o_cnt_done(cnt_done_b), .o_init(init_b), .o_ctrl_pc_en(pc_en_b), .o_dbus_cyc(dbus_cyc_b),
    .i_dbus_ack(dbus_ack), .o_dbus_err(dbus_err_b));

  // Observed vector: {ibus_cyc, wb_en, rf_rreq, cnt_en, cnt[4:0], cnt_done, init, pc_en, dbus_cyc, dbus_err}
  logic        sel;
  logic [13:0] obs;
  assign obs = sel ? {ibus_cyc_b, wb_en_b, rf_rreq_b, cnt_en_b, cnt_b, cnt_done_b, init_b, pc_en_b, dbus_cyc_b, dbus_err_b}
                   : {ibus_cyc_a, wb_en_a, rf_rreq_a, cnt_en_a, cnt_a, cnt_done_a, init_a, pc_en_a, dbus_cyc_a, dbus_err_a};

  typedef struct packed {
    logic ibus_ack, rf_ready, dbus_ack, sh_done, two, dbus, shift;
  } in_t;

  in_t         drv_q[$];
  logic [13:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cur_w;
  bit          err_pending, junk;
  logic        cur_two, cur_dbus, cur_shift;

  function automatic logic [13:0] mk(input logic ibus, wb, rreq, en, input logic [4:0] c,
                                     input logic done, init, pc, dcyc);
    return {ibus, wb, rreq, en, c, done, init, pc, dcyc, 1'b0};
  endfunction

  // ph: 0 fetch, 1 rf request, 2 mem, 3 shift, 4 serial pass; acks not owned by the phase are noise
  task automatic push(input int ph, input bit fin, input logic [13:0] o);
    in_t v;
    logic [13:0] e;
    e = o;
    v.ibus_ack = (ph == 0) ? fin : (junk ? 1'($urandom) : 1'b0);
    v.rf_ready = (ph == 1) ? fin : (junk ? 1'($urandom) : 1'b0);
    v.dbus_ack = (ph == 2) ? fin : (junk ? 1'($urandom) : 1'b0);
    v.sh_done  = (ph == 3) ? fin : (junk ? 1'($urandom) : 1'b0);
    v.two = cur_two; v.dbus = cur_dbus; v.shift = cur_shift;
    if (err_pending) begin
      e[0] = 1'b1;
      err_pending = 1'b0;
    end
    drv_q.push_back(v);
    exp_q.push_back(e);
  endtask

  task automatic add_pass(input bit is_init);
    int n;
    n = 32 / cur_w;
    for (int i = 0; i < n; i++)
      push(4, 1'b0, mk(0, 0, 0, 1, 5'(i * cur_w), i == n - 1, is_init, !is_init, 0));
  endtask

  task automatic add_instr(input bit two, dbus, shift, input int fw, rw1, mw, sw, rw2);
    cur_two = two; cur_dbus = dbus; cur_shift = shift;
    for (int i = 0; i <= fw; i++)  push(0, i == fw, mk(1, i == fw, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i <= rw1; i++) push(1, i == rw1, mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    if (two) begin
      add_pass(1'b1);
      if (dbus) begin
        if (TO_EN && mw >= TO) begin
          for (int i = 0; i < TO; i++) push(2, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
          err_pending = 1'b1;
          return;
        end
        for (int i = 0; i <= mw; i++) push(2, i == mw, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      end else if (shift) begin
        for (int i = 0; i <= sw; i++) push(3, i == sw, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      for (int i = 0; i <= rw2; i++) push(1, i == rw2, mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    end
    add_pass(1'b0);
  endtask

  task automatic add_tail();
    cur_two = 1'b0; cur_dbus = 1'b0; cur_shift = 1'b0;
    push(0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic drive_idle();
    {ibus_ack, rf_ready, dbus_ack, sh_done, two_stage_op, dbus_en, shift_op} = '0;
  endtask

  task automatic start(input bit s);
    @(negedge clk);
    sel = s;
    cur_w = s ? 4 : 1;
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    drv_q.delete();
    exp_q.delete();
    err_pending = 1'b0;
    junk = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {ibus_ack, rf_ready, dbus_ack, sh_done, two_stage_op, dbus_en, shift_op} = 7'($urandom);
      #1;
      checks++;
      if (obs !== 14'h0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, 14'h0);
      end
      @(negedge clk);
    end
    drive_idle();
    ibus_ack = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 14'h0) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs, 14'h0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs !== mk(1, 1, 0, 0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL first_fetch got=%h exp=%h", obs, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_addi_w1();
    start(1'b0);
    add_instr(0, 0, 0, 0, 0, 0, 0, 0);
    add_tail();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      {ibus_ack, rf_ready, dbus_ack, sh_done, two_stage_op, dbus_en, shift_op} = drv_q[i];
      #1;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL addi_w1 cyc=%0d got=%h exp=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_lw_w4();
    start(1'b1);
    add_instr(1, 1, 0, 0, 0, 3, 0, 0);
    add_tail();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      {ibus_ack, rf_ready, dbus_ack, sh_done, two_stage_op, dbus_en, shift_op} = drv_q[i];
      #1;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL lw_w4 cyc=%0d got=%h exp=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_shift();
    start(1'b1);
    add_instr(1, 0, 1, 0, 0, 0, 4, 0);
    add_instr(1, 0, 1, 1, 0, 0, 0, 1);
    add_tail();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      {ibus_ack, rf_ready, dbus_ack, sh_done, two_stage_op, dbus_en, shift_op} = drv_q[i];
      #1;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL shift cyc=%0d got=%h exp=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_beq();
    start(1'b0);
    add_instr(1, 0, 0, 0, 0, 0, 0, 0);
    add_tail();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      {ibus_ack, rf_ready, dbus_ack, sh_done, two_stage_op, dbus_en, shift_op} = drv_q[i];
      #1;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL beq cyc=%0d got=%h exp=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    start(1'b0);
    add_instr(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      {ibus_ack, rf_ready, dbus_ack, sh_done, two_stage_op, dbus_en, shift_op} = drv_q[i];
      #1;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", i, obs, exp_q[i]);
      end
    end
    #1;
    rst = 1'b1;
    drive_idle();
    dbus_ack = 1'b1;
    #1;
    checks++;
    if (obs !== 14'h0) begin
      failures++;
      $display("FAIL reset_mid_async got=%h exp=%h", obs, 14'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    drv_q.delete();
    exp_q.delete();
    junk = 1'b1;
    add_instr(0, 0, 0, 2, 1, 0, 0, 0);
    add_tail();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      {ibus_ack, rf_ready, dbus_ack, sh_done, two_stage_op, dbus_en, shift_op} = drv_q[i];
      #1;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_mid_restart cyc=%0d got=%h exp=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    start(1'b1);
    add_instr(1, 1, 0, 0, 0, 8, 0, 0);
    add_instr(0, 0, 0, 0, 0, 0, 0, 0);
    add_tail();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      {ibus_ack, rf_ready, dbus_ack, sh_done, two_stage_op, dbus_en, shift_op} = drv_q[i];
      #1;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int rep = 0; rep < 2; rep++) begin
      start(rep[0]);
      junk = 1'b1;
      for (int k = 0; k < 12; k++)
        add_instr(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 3));
      add_tail();
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        {ibus_ack, rf_ready, dbus_ack, sh_done, two_stage_op, dbus_en, shift_op} = drv_q[i];
        #1;
        checks++;
        if (obs !== exp_q[i]) begin
          failures++;
          $display("FAIL random w=%0d cyc=%0d got=%h exp=%h", cur_w, i, obs, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    drive_idle();
    test_reset();
    test_addi_w1();
    test_lw_w4();
    test_shift();
    test_beq();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
